// File: rtl/globals.sv
// Shared control-field encodings for the microprogrammed control unit and the execution datapath.
package globals;

    localparam int DP_DW = 12;
    typedef logic [DP_DW-1:0] dp_word_t;

    localparam logic [3:0] SBUS_IN       = 4'd0;
    localparam logic [3:0] SBUS_ADDCONST = 4'd1;
    localparam logic [3:0] SBUS_R0       = 4'd2;
    localparam logic [3:0] SBUS_R1       = 4'd3;
    localparam logic [3:0] SBUS_R2       = 4'd4;
    localparam logic [3:0] SBUS_R3       = 4'd5;
    localparam logic [3:0] SBUS_ACC      = 4'd6;

    localparam logic [3:0] ALU_PASS      = 4'd0;
    localparam logic [3:0] ALU_AND       = 4'd1;
    localparam logic [3:0] ALU_ADD       = 4'd2;
    localparam logic [3:0] ALU_SUBS      = 4'd3;

    localparam logic [2:0] SHFT_NIL      = 3'd0;
    localparam logic [2:0] SHFT_SHR      = 3'd1;
    localparam logic [2:0] SHFT_SHL      = 3'd2;

    localparam logic [3:0] DST_NIL       = 4'd0;
    localparam logic [3:0] DST_R0        = 4'd1;
    localparam logic [3:0] DST_R1        = 4'd2;
    localparam logic [3:0] DST_R2        = 4'd3;
    localparam logic [3:0] DST_R3        = 4'd4;
    localparam logic [3:0] DST_ACC       = 4'd5;

    localparam logic       O_NIL         = 1'b0;
    localparam logic       O_WR          = 1'b1;

endpackage

// File: rtl/dp_out_fifo.sv
// Show-ahead output FIFO for alu_datapath; only compiled when ALU_DP_OFIFO_EN is defined.
`ifdef ALU_DP_OFIFO_EN
module dp_out_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          wr_en;
    logic          rd_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = rd_en ? rptr_q + 1'b1 : rptr_q;
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule
`endif

// File: rtl/alu_datapath.sv
// Execution datapath: R0-R3, ACC, S-bus mux, ALU, shifter, carry/zero flags and a buffered output port.
// Define ALU_DP_OFIFO_EN to buffer the output through dp_out_fifo instead of a single register.
module alu_datapath
    import globals::*;
#(
    parameter int DW          = 12,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_ot,
    input  logic [3:0]    ctl_sbs,
    input  logic [3:0]    ctl_alu,
    input  logic [2:0]    ctl_shft,
    input  logic [3:0]    ctl_dest,
    input  logic [11:0]   ctl_const,
    input  logic [DW-1:0] data_in,
    output logic          in_ack,
    output logic          carry,
    output logic          zero,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf
);

    logic [DW-1:0] r_q [4];
    logic [DW-1:0] r_d [4];
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] const_ext, sbus, sh_res;
    logic [DW:0]   alu_res;
    logic          sh_carry;
    logic          carry_q, zero_q, ovf_q;
    logic          push, pop, drop;

    generate
        if (DW > 12) begin : g_const_wide
            assign const_ext = {{(DW-12){1'b0}}, ctl_const};
        end else begin : g_const_narrow
            assign const_ext = ctl_const[DW-1:0];
        end
    endgenerate

    always_comb begin
        sbus = '0;
        case (ctl_sbs)
            SBUS_IN:       sbus = data_in;
            SBUS_ADDCONST: sbus = const_ext;
            SBUS_R0:       sbus = r_q[0];
            SBUS_R1:       sbus = r_q[1];
            SBUS_R2:       sbus = r_q[2];
            SBUS_R3:       sbus = r_q[3];
            SBUS_ACC:      sbus = acc_q;
            default:       sbus = '0;
        endcase
    end

    // Bit DW of the widened subtract is the borrow, i.e. set iff ACC < S unsigned.
    always_comb begin
        alu_res = {1'b0, sbus};
        case (ctl_alu)
            ALU_PASS: alu_res = {1'b0, sbus};
            ALU_AND:  alu_res = {1'b0, acc_q & sbus};
            ALU_ADD:  alu_res = {1'b0, acc_q} + {1'b0, sbus};
            ALU_SUBS: alu_res = {1'b0, acc_q} - {1'b0, sbus};
            default:  alu_res = {1'b0, sbus};
        endcase
    end

    always_comb begin
        sh_res   = alu_res[DW-1:0];
        sh_carry = alu_res[DW];
        case (ctl_shft)
            SHFT_NIL: ;
            SHFT_SHR: begin
                sh_res   = {1'b0, alu_res[DW-1:1]};
                sh_carry = alu_res[0];
            end
            SHFT_SHL: begin
                sh_res   = {alu_res[DW-2:0], 1'b0};
                sh_carry = alu_res[DW-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        r_d   = r_q;
        acc_d = acc_q;
        case (ctl_dest)
            DST_NIL: ;
            DST_R0:  r_d[0] = sh_res;
            DST_R1:  r_d[1] = sh_res;
            DST_R2:  r_d[2] = sh_res;
            DST_R3:  r_d[3] = sh_res;
            DST_ACC: acc_d  = sh_res;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= '0;
            end
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            r_q     <= r_d;
            acc_q   <= acc_d;
            carry_q <= sh_carry;
            zero_q  <= (sh_res == '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign in_ack = !rst && (ctl_sbs == SBUS_IN);
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign push   = (ctl_ot == O_WR);
    assign pop    = out_valid && out_ready;

`ifdef ALU_DP_OFIFO_EN
    logic fifo_full, fifo_empty;

    dp_out_fifo #(
        .DW    (DW),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (sh_res),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (data_out)
    );

    assign out_valid = !fifo_empty;
    assign drop      = push && fifo_full && !pop;
`else
    logic [DW-1:0] dout_q, dout_d;
    logic          ovalid_q, ovalid_d;
    logic          unused_depth;

    assign unused_depth = ^OFIFO_DEPTH;

    // A push onto an unread word overwrites it; the lost word is flagged via ovf.
    always_comb begin
        dout_d   = dout_q;
        ovalid_d = ovalid_q;
        if (pop) begin
            ovalid_d = 1'b0;
        end
        if (push) begin
            dout_d   = sh_res;
            ovalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign data_out  = dout_q;
    assign out_valid = ovalid_q;
    assign drop      = push && ovalid_q && !out_ready;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: reference model for registers/flags, scoreboard queue for the output port.
module tb_alu_datapath;
    import globals::*;

    localparam int DW = 12;
`ifdef ALU_DP_OFIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctl_ot = 1'b0;
    logic [3:0]    ctl_sbs = 4'd0;
    logic [3:0]    ctl_alu = 4'd0;
    logic [2:0]    ctl_shft = 3'd0;
    logic [3:0]    ctl_dest = 4'd0;
    logic [11:0]   ctl_const = 12'd0;
    logic [DW-1:0] data_in = '0;
    logic          in_ack, carry, zero, out_valid, ovf;
    logic [DW-1:0] data_out;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    alu_datapath #(
        .DW          (DW),
        .OFIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_ot    (ctl_ot),
        .ctl_sbs   (ctl_sbs),
        .ctl_alu   (ctl_alu),
        .ctl_shft  (ctl_shft),
        .ctl_dest  (ctl_dest),
        .ctl_const (ctl_const),
        .data_in   (data_in),
        .in_ack    (in_ack),
        .carry     (carry),
        .zero      (zero),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    int       n_vec = 0;
    int       n_bad = 0;
    dp_word_t m_r [4];
    dp_word_t m_acc;
    logic     m_ovf;
    logic     m_c, m_z;
    dp_word_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("out_pending", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("out_data", {20'b0, data_out}, {20'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_acc = '0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // One microinstruction: called and returning at posedge+1.
    task automatic op(input logic ot, input logic [3:0] sbs, input logic [3:0] alu,
                      input logic [2:0] sh, input logic [3:0] dst, input logic [11:0] k,
                      input dp_word_t din, input logic rdy);
        int unsigned s, a, r;
        logic        c, pop_now;
        ctl_ot = ot; ctl_sbs = sbs; ctl_alu = alu; ctl_shft = sh;
        ctl_dest = dst; ctl_const = k; data_in = din; out_ready = rdy;
        a = m_acc;
        case (sbs)
            SBUS_IN:       s = din;
            SBUS_ADDCONST: s = k;
            SBUS_R0:       s = m_r[0];
            SBUS_R1:       s = m_r[1];
            SBUS_R2:       s = m_r[2];
            SBUS_R3:       s = m_r[3];
            SBUS_ACC:      s = m_acc;
            default:       s = 0;
        endcase
        case (alu)
            ALU_AND:  begin r = a & s; c = 1'b0; end
            ALU_ADD:  begin r = a + s; c = (r >= 4096); r = r % 4096; end
            ALU_SUBS: begin c = (a < s); r = (a - s) & 32'hFFF; end
            default:  begin r = s; c = 1'b0; end
        endcase
        case (sh)
            SHFT_SHR: begin c = r[0]; r = r >> 1; end
            SHFT_SHL: begin c = r[11]; r = (r << 1) & 32'hFFF; end
            default: ;
        endcase
        m_c = c;
        m_z = (r == 0);
        #1;
        check("in_ack", {31'b0, in_ack}, {31'b0, sbs == SBUS_IN});
        pop_now = rdy && (exp_q.size() != 0);
        if (ot) begin
            if (exp_q.size() < CAP || pop_now) begin
                exp_q.push_back(dp_word_t'(r));
            end else begin
                m_ovf = 1'b1;
`ifndef ALU_DP_OFIFO_EN
                exp_q[exp_q.size()-1] = dp_word_t'(r);
`endif
            end
        end
        case (dst)
            DST_R0:  m_r[0] = dp_word_t'(r);
            DST_R1:  m_r[1] = dp_word_t'(r);
            DST_R2:  m_r[2] = dp_word_t'(r);
            DST_R3:  m_r[3] = dp_word_t'(r);
            DST_ACC: m_acc  = dp_word_t'(r);
            default: ;
        endcase
        @(posedge clk);
        #1;
        check("carry", {31'b0, carry}, {31'b0, m_c});
        check("zero", {31'b0, zero}, {31'b0, m_z});
        check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("data_out_head", {20'b0, data_out}, {20'b0, exp_q[0]});
        end
    endtask

    task automatic nop(input logic rdy);
        op(O_NIL, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h000, '0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            nop(1'b1);
        end
        check("drain_empty", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic ld(input logic [3:0] dst, input logic [11:0] k);
        op(O_NIL, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, dst, k, '0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [3:0] src, input dp_word_t exp);
        op(O_WR, src, ALU_PASS, SHFT_NIL, DST_NIL, 12'h000, '0, 1'b0);
        check(tag, {20'b0, data_out}, {20'b0, exp});
        drain();
    endtask

    task automatic async_reset();
        ctl_sbs = SBUS_IN;
        #3 rst = 1'b1;
        #1;
        check("rst_carry", {31'b0, carry}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_data_out", {20'b0, data_out}, 32'd0);
        check("rst_in_ack", {31'b0, in_ack}, 32'd0);
        model_clear();
        ctl_ot = O_NIL; ctl_sbs = SBUS_ADDCONST; ctl_dest = DST_NIL; ctl_const = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Async reset mid-cycle with live state
        op(O_WR, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_R0, 12'h5A5, '0, 1'b0);
        check("pre_rst_dout", {20'b0, data_out}, 32'h5A5);
        op(O_NIL, SBUS_R0, ALU_PASS, SHFT_SHR, DST_NIL, 12'h000, '0, 1'b0);
        check("pre_rst_carry", {31'b0, carry}, 32'd1);
        async_reset();
        rd("rst_R0", SBUS_R0, 12'h000);
        rd("rst_ACC", SBUS_ACC, 12'h000);

        // ADD with carry-out and zero result
        ld(DST_ACC, 12'h001);
        ld(DST_R0, 12'hFFF);
        op(O_NIL, SBUS_R0, ALU_ADD, SHFT_NIL, DST_R1, 12'h000, '0, 1'b0);
        check("add_carry", {31'b0, carry}, 32'd1);
        check("add_zero", {31'b0, zero}, 32'd1);
        rd("add_R1", SBUS_R1, 12'h000);

        // SUBS borrow, then SHR
        ld(DST_ACC, 12'h003);
        ld(DST_R2, 12'h005);
        op(O_NIL, SBUS_R2, ALU_SUBS, SHFT_NIL, DST_R2, 12'h000, '0, 1'b0);
        check("subs_borrow", {31'b0, carry}, 32'd1);
        check("subs_zero", {31'b0, zero}, 32'd0);
        rd("subs_R2", SBUS_R2, 12'hFFE);
        ld(DST_R0, 12'h006);
        op(O_NIL, SBUS_R0, ALU_PASS, SHFT_SHR, DST_R0, 12'h000, '0, 1'b0);
        check("shr_carry", {31'b0, carry}, 32'd0);
        rd("shr_R0", SBUS_R0, 12'h003);

        // External input and DST_NIL
        op(O_NIL, SBUS_IN, ALU_PASS, SHFT_NIL, DST_R3, 12'h000, 12'h123, 1'b0);
        op(O_NIL, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h777, '0, 1'b0);
        rd("in_R3", SBUS_R3, 12'h123);
        rd("nil_R0", SBUS_R0, 12'h003);

        // Output overflow with consumer stalled, then drain in order
        for (int i = 0; i < 5; i++) begin
            op(O_WR, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h101 + 12'(i), '0, 1'b0);
        end
        check("ovf_set", {31'b0, ovf}, 32'd1);
        drain();

        // Full buffer, push and pop together: no loss
        async_reset();
        for (int i = 0; i < CAP; i++) begin
            op(O_WR, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h2A0 + 12'(i), '0, 1'b0);
        end
        op(O_WR, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h2AA, '0, 1'b1);
        check("full_pushpop_ovf", {31'b0, ovf}, 32'd0);
        drain();
`ifndef ALU_DP_OFIFO_EN
        op(O_WR, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h3C1, '0, 1'b0);
        op(O_WR, SBUS_ADDCONST, ALU_PASS, SHFT_NIL, DST_NIL, 12'h3C2, '0, 1'b0);
        check("overwrite_ovf", {31'b0, ovf}, 32'd1);
        check("overwrite_dout", {20'b0, data_out}, 32'h3C2);
        drain();
`endif

        // Random microinstructions, including undefined encodings
        async_reset();
        for (int i = 0; i < 60; i++) begin
            op(1'($urandom), 4'($urandom_range(0, 8)), 4'($urandom_range(0, 5)),
               3'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 12'($urandom),
               12'($urandom), 1'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
